// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: register offsets, field widths and CTRL bit index shared by the RGB PWM block.
package rgb_pwm_pkg;
  localparam int DUTY_W = 8;
  localparam int PRESCALE_W = 16;
  localparam int CTRL_EN = 0;
  typedef enum logic [2:0] {
    OFF_CTRL     = 3'd0,
    OFF_PRESCALE = 3'd1,
    OFF_DUTY_R   = 3'd2,
    OFF_DUTY_G   = 3'd3,
    OFF_DUTY_B   = 3'd4,
    OFF_STATUS   = 3'd5,
    OFF_FADE     = 3'd6
  } reg_off_e;
endpackage

// File: rtl/rgb_pwm_channel.sv
// rgb_pwm_channel: active duty tracking (full load or fade stepping) and registered active-low pin.
// Fade stepping is built when RGB_PWM_FADE_EN is defined.
module rgb_pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [DUTY_W-1:0] i_shadow,
  input  logic              i_wrap,
  input  logic              i_step,
  input  logic              i_en,
  input  logic [DUTY_W-1:0] i_cnt,
  output logic              o_pin_n
);
  logic [DUTY_W-1:0] r_active;
  logic [DUTY_W-1:0] w_next;
  logic              w_unused;
  assign w_unused = i_wrap ^ i_step;
`ifdef RGB_PWM_FADE_EN
  assign w_next = !i_en ? i_shadow :
                  !i_step ? r_active :
                  (r_active < i_shadow) ? r_active + 1'b1 :
                  (r_active > i_shadow) ? r_active - 1'b1 : r_active;
`else
  assign w_next = (!i_en || i_wrap) ? i_shadow : r_active;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_active <= '0;
      o_pin_n  <= 1'b1;
    end else begin
      r_active <= w_next;
      o_pin_n  <= !(i_en && i_cnt < r_active);
    end
  end
endmodule

// File: rtl/rgb_pwm_iomem.sv
// rgb_pwm_iomem: iomem-bus slave driving a three-channel active-low RGB PWM.
// Define RGB_PWM_FADE_EN to add the FADE register and gradual duty stepping.
module rgb_pwm_iomem
  import rgb_pwm_pkg::*;
#(
  parameter logic [7:0]            ADDR_HI      = 8'h04,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RST = 16'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        ledr_n,
  output logic        ledg_n,
  output logic        ledb_n
);
  logic                  r_en;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pre;
  logic [DUTY_W-1:0]     r_duty_r;
  logic [DUTY_W-1:0]     r_duty_g;
  logic [DUTY_W-1:0]     r_duty_b;
  logic [DUTY_W-1:0]     r_cnt;
  logic                  r_flag;
  logic                  w_sel;
  logic                  w_wr;
  logic                  w_b0;
  logic [2:0]            w_off;
  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_step;
  logic [31:0]           w_rd_data;
  logic                  w_unused;

  assign w_sel  = iomem_valid && !iomem_ready && iomem_addr[31:24] == ADDR_HI;
  assign w_wr   = w_sel && |iomem_wstrb;
  assign w_b0   = w_wr && iomem_wstrb[0];
  assign w_off  = iomem_addr[4:2];
  assign w_tick = r_en && r_pre == r_prescale;
  assign w_wrap = w_tick && r_cnt == '1;
  assign w_unused = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata[31:16]};

`ifdef RGB_PWM_FADE_EN
  logic [DUTY_W-1:0] r_fade_div;
  logic [DUTY_W-1:0] r_wrap_cnt;
  assign w_step = w_wrap && r_wrap_cnt == r_fade_div;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fade_div <= '0;
      r_wrap_cnt <= '0;
    end else begin
      if (w_b0 && w_off == OFF_FADE) r_fade_div <= iomem_wdata[7:0];
      if (w_wrap) r_wrap_cnt <= w_step ? '0 : r_wrap_cnt + 1'b1;
    end
  end
`else
  assign w_step = w_wrap;
`endif

  always_comb begin
    w_rd_data = '0;
    case (w_off)
      OFF_CTRL:     w_rd_data[CTRL_EN] = r_en;
      OFF_PRESCALE: w_rd_data[PRESCALE_W-1:0] = r_prescale;
      OFF_DUTY_R:   w_rd_data[DUTY_W-1:0] = r_duty_r;
      OFF_DUTY_G:   w_rd_data[DUTY_W-1:0] = r_duty_g;
      OFF_DUTY_B:   w_rd_data[DUTY_W-1:0] = r_duty_b;
      OFF_STATUS:   w_rd_data[DUTY_W:0] = {r_flag, r_cnt};
`ifdef RGB_PWM_FADE_EN
      OFF_FADE:     w_rd_data[DUTY_W-1:0] = r_fade_div;
`endif
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      r_en        <= 1'b0;
      r_prescale  <= PRESCALE_RST;
      r_duty_r    <= '0;
      r_duty_g    <= '0;
      r_duty_b    <= '0;
      r_pre       <= '0;
      r_cnt       <= '0;
      r_flag      <= 1'b0;
    end else begin
      iomem_ready <= w_sel;
      iomem_rdata <= w_sel ? w_rd_data : '0;
      if (w_b0 && w_off == OFF_CTRL) r_en <= iomem_wdata[CTRL_EN];
      if (w_b0 && w_off == OFF_PRESCALE) r_prescale[7:0] <= iomem_wdata[7:0];
      if (w_wr && iomem_wstrb[1] && w_off == OFF_PRESCALE) r_prescale[15:8] <= iomem_wdata[15:8];
      if (w_b0 && w_off == OFF_DUTY_R) r_duty_r <= iomem_wdata[7:0];
      if (w_b0 && w_off == OFF_DUTY_G) r_duty_g <= iomem_wdata[7:0];
      if (w_b0 && w_off == OFF_DUTY_B) r_duty_b <= iomem_wdata[7:0];
      // a wrap in the same cycle as the STATUS read keeps the flag set
      r_flag <= w_wrap || (r_flag && !(w_sel && !(|iomem_wstrb) && w_off == OFF_STATUS));
      r_pre  <= (!r_en || w_tick || (w_wr && w_off == OFF_PRESCALE)) ? '0 : r_pre + 1'b1;
      r_cnt  <= !r_en ? '0 : w_tick ? r_cnt + 1'b1 : r_cnt;
    end
  end

  rgb_pwm_channel u_r (.clk(clk), .resetn(resetn), .i_shadow(r_duty_r), .i_wrap(w_wrap),
    .i_step(w_step), .i_en(r_en), .i_cnt(r_cnt), .o_pin_n(ledr_n));
  rgb_pwm_channel u_g (.clk(clk), .resetn(resetn), .i_shadow(r_duty_g), .i_wrap(w_wrap),
    .i_step(w_step), .i_en(r_en), .i_cnt(r_cnt), .o_pin_n(ledg_n));
  rgb_pwm_channel u_b (.clk(clk), .resetn(resetn), .i_shadow(r_duty_b), .i_wrap(w_wrap),
    .i_step(w_step), .i_en(r_en), .i_cnt(r_cnt), .o_pin_n(ledb_n));
endmodule

// File: tb/tb_rgb_pwm_iomem.sv
// tb_rgb_pwm_iomem: randomized register and PWM duty checks against a register-map model.
module tb_rgb_pwm_iomem;
  localparam logic [7:0] HI = 8'h04;
`ifdef RGB_PWM_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  wstrb = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ledr_n, ledg_n, ledb_n;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mdl [0:7];

  rgb_pwm_iomem #(.ADDR_HI(HI), .PRESCALE_RST(16'd0)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata),
    .ledr_n(ledr_n), .ledg_n(ledg_n), .ledb_n(ledb_n));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] q);
    bit got;
    got = 1'b0;
    q = '0;
    @(negedge clk);
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        got = 1'b1;
        q = rdata;
      end
    end
    valid = 1'b0; wstrb = '0;
    check("ready", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d);
    logic [31:0] q;
    bus({HI, 19'd0, o, 2'b00}, 4'hF, d, q);
  endtask

  task automatic rd(input logic [2:0] o, output logic [31:0] q);
    bus({HI, 19'd0, o, 2'b00}, 4'h0, 32'h0, q);
  endtask

  task automatic count(input int n, output int lr, output int lg, output int lb);
    lr = 0; lg = 0; lb = 0;
    repeat (n) begin
      @(negedge clk);
      if (!ledr_n) lr++;
      if (!ledg_n) lg++;
      if (!ledb_n) lb++;
    end
  endtask

  function automatic logic [31:0] msk(input logic [2:0] o);
    return o == 3'd1 ? 32'hFFFF : (o >= 3'd2 && o <= 3'd4) ? 32'hFF :
           (o == 3'd6 && FADE) ? 32'hFF : 32'h0;
  endfunction

  initial begin
    #200_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    logic [2:0]  o;
    logic [3:0]  s;
    logic [31:0] d;
    int lr, lg, lb, p, dr, dg, db, found;
    #12;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_leds", {29'd0, ledr_n, ledg_n, ledb_n}, 32'd7);
    #20 resetn = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), q);
      check($sformatf("rst_rd%0d", i), q, mdl[i]);
    end
    check("rst_leds2", {29'd0, ledr_n, ledg_n, ledb_n}, 32'd7);

    // random register traffic with EN left off, checked against the map model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(1, 7));
      s = 4'($urandom);
      d = $urandom;
      bus({HI, 19'd0, o, 2'b00}, s, d, q);
      for (int b = 0; b < 4; b++) if (s[b]) mdl[o][8*b +: 8] = d[8*b +: 8];
      mdl[o] &= msk(o);
      rd(o, q);
      check($sformatf("reg_rd%0d", o), q, mdl[o]);
    end

    wr(3'd4, 32'h0);
    bus({HI, 19'd0, 3'd4, 2'b00}, 4'b0010, 32'hFFFF_FFFF, q);
    rd(3'd4, q);
    check("wstrb_b", q, 32'h0);

    @(negedge clk);
    valid = 1'b1; addr = {8'h05, 19'd0, 3'd4, 2'b00}; wstrb = 4'hF; wdata = 32'h55;
    found = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ready) found++;
    end
    valid = 1'b0; wstrb = '0;
    check("unsel_ready", 32'(found), 32'd0);
    rd(3'd4, q);
    check("unsel_duty", q, 32'h0);

    for (int it = 0; it < 4; it++) begin
      p  = it == 0 ? 0 : $urandom_range(0, 3);
      dr = it == 0 ? 64 : $urandom_range(0, 255);
      dg = it == 0 ? 0 : $urandom_range(0, 255);
      db = it == 0 ? 255 : $urandom_range(0, 255);
      wr(3'd0, 32'd0);
      wr(3'd1, 32'(p));
      wr(3'd2, 32'(dr));
      wr(3'd3, 32'(dg));
      wr(3'd4, 32'(db));
      wr(3'd0, 32'd1);
      repeat (10) @(negedge clk);
      count(256 * (p + 1), lr, lg, lb);
      check($sformatf("pwm_r_p%0d_d%0d", p, dr), 32'(lr), 32'(dr * (p + 1)));
      check($sformatf("pwm_g_p%0d_d%0d", p, dg), 32'(lg), 32'(dg * (p + 1)));
      check($sformatf("pwm_b_p%0d_d%0d", p, db), 32'(lb), 32'(db * (p + 1)));
    end

    // duty change mid-period must wait for the next wrap
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd64);
    wr(3'd3, 32'd0);
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd1);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      rd(3'd5, q);
      if (q[7:0] < 8'd100) found = 1;
    end
    check("find_cnt", 32'(found), 32'd1);
    wr(3'd3, 32'd200);
    count(140, lr, lg, lb);
    check("g_hold", 32'(lg), 32'd0);
`ifndef RGB_PWM_FADE_EN
    repeat (300) @(negedge clk);
    count(256, lr, lg, lb);
    check("g_200", 32'(lg), 32'd200);
`endif

    wr(3'd0, 32'd0);
    wr(3'd1, 32'd3);
    rd(3'd5, q);
    rd(3'd5, q);
    check("stat_clr", q, 32'h0);
    wr(3'd0, 32'd1);
    count(1024, lr, lg, lb);
    check("p3_r", 32'(lr), 32'd256);
    rd(3'd5, q);
    check("wrap_set", {31'd0, q[8]}, 32'd1);
    rd(3'd5, q);
    check("wrap_clr", {31'd0, q[8]}, 32'd0);

`ifdef RGB_PWM_FADE_EN
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd6, 32'd1);
    wr(3'd0, 32'd1);
    wr(3'd2, 32'd4);
    repeat (256 * 12) @(negedge clk);
    count(256, lr, lg, lb);
    check("fade_r", 32'(lr), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
